// File: rtl/load_alarm_if.sv
// Bundle between the load counter / shedder side and the load_alarm qualifier.
// master drives the counter level, full flag, ack and peak clear; slave drives warn/alarm/shed/peak.
interface load_alarm_if;
   logic       Q2;
   logic       Q1;
   logic       Q0;
   logic       A;
   logic       ack;
   logic       peak_clr;
   logic       warn;
   logic       alarm;
   logic       shed;
   logic [2:0] peak;

   modport master (
      output Q2, Q1, Q0, A, ack, peak_clr,
      input  warn, alarm, shed, peak
   );

   modport slave (
      input  Q2, Q1, Q0, A, ack, peak_clr,
      output warn, alarm, shed, peak
   );
endinterface

// File: rtl/load_alarm.sv
// Qualifies the load counter's full flag into warn/alarm with hysteresis, a shed pulse and a hold-off.
// Optional peak-level tracking is enabled by defining LOAD_PEAK_EN.
module load_alarm #(
   parameter int FULL_CYCLES = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int WARN_LEVEL  = 5,
   parameter int CLEAR_LEVEL = 3
) (
   input  logic         clk,
   input  logic         reset,
   load_alarm_if.slave  bus
);

   typedef enum logic [1:0] {
      NORMAL,
      WARN,
      ALARM,
      HOLD
   } stateT;

   localparam logic [7:0] FULL_LAST = 8'(FULL_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [2:0] WARN_LVL  = 3'(WARN_LEVEL);
   localparam logic [2:0] CLEAR_LVL = 3'(CLEAR_LEVEL);

   stateT      state;
   stateT      stateNext;
   logic [7:0] cnt;
   logic [7:0] cntNext;
   logic       shedReg;
   logic       shedNext;
   logic [2:0] level;

   assign level = {bus.Q2, bus.Q1, bus.Q0};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= NORMAL;
         cnt     <= 8'd0;
         shedReg <= 1'b0;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         shedReg <= shedNext;
      end
   end

   // cnt doubles as WARN dwell counter and HOLD timer; every state change zeroes it
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      shedNext  = 1'b0;
      case (state)
         NORMAL: begin
            cntNext = 8'd0;
            if (level >= WARN_LVL) begin
               stateNext = WARN;
            end
         end
         WARN: begin
            if (level < WARN_LVL) begin
               stateNext = NORMAL;
               cntNext   = 8'd0;
            end else if (!bus.A) begin
               cntNext = 8'd0;
            end else if (cnt == FULL_LAST) begin
               stateNext = ALARM;
               cntNext   = 8'd0;
               shedNext  = 1'b1;
            end else begin
               cntNext = cnt + 8'd1;
            end
         end
         ALARM: begin
            if (bus.ack && (level <= CLEAR_LVL)) begin
               stateNext = HOLD;
               cntNext   = 8'd0;
            end
         end
         HOLD: begin
            if (bus.A) begin
               stateNext = ALARM;
               cntNext   = 8'd0;
               shedNext  = 1'b1;
            end else if (cnt == HOLD_LAST) begin
               stateNext = NORMAL;
               cntNext   = 8'd0;
            end else begin
               cntNext = cnt + 8'd1;
            end
         end
         default: begin
            stateNext = NORMAL;
            cntNext   = 8'd0;
         end
      endcase
   end

   assign bus.warn  = (state == WARN) || (state == HOLD);
   assign bus.alarm = (state == ALARM);
   assign bus.shed  = shedReg;

`ifdef LOAD_PEAK_EN
   logic [2:0] peakReg;

   // a clear reloads from the live level rather than zero so the next max starts from now
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         peakReg <= 3'd0;
      end else if (bus.peak_clr) begin
         peakReg <= level;
      end else if (level > peakReg) begin
         peakReg <= level;
      end
   end

   assign bus.peak = peakReg;
`else
   logic unusedPeakClr;

   assign unusedPeakClr = bus.peak_clr;
   assign bus.peak      = 3'b000;
`endif

endmodule

// File: doc/load_alarm.md
# load_alarm

Downstream consumer of the 3-bit saturating load-level counter: takes its level bits Q2..Q0 and full flag A and turns them into a qualified warning/alarm with hysteresis, a one-cycle shed request and a hold-off period. It sits between the load counter and the load-shedding controller. It filters transient full indications so the shedder acts only on sustained overload.

## Interface
- FULL_CYCLES, 4: consecutive sampled cycles of A=1 in WARN needed to raise alarm; legal range 1..255
- HOLD_CYCLES, 8: length of post-alarm hold-off; legal range 1..255
- WARN_LEVEL, 5: level (0..7) at or above which WARN is entered; legal range 1..7
- CLEAR_LEVEL, 3: level at or below which an acknowledged alarm may clear; must be < WARN_LEVEL
- clk  input  1  rising-edge clock, shared with the load counter
- reset  input  1  asynchronous, active-low reset
- Q2, Q1, Q0  input  1 each  load level from the counter, level = {Q2,Q1,Q0}
- A  input  1  counter full flag (level == 7)
- ack  input  1  alarm acknowledge from the shedder, level-sensitive
- peak_clr  input  1  synchronous clear of the peak register
- warn  output  1  high in WARN or HOLD
- alarm  output  1  high in ALARM
- shed  output  1  one-cycle pulse on every entry into ALARM
- peak  output  3  highest level seen since reset or last peak_clr

## Operation
- Reset (reset=0), asynchronous: state=NORMAL, cnt=0, shed=0, peak=0; hence warn=0, alarm=0.
- All inputs sampled on the rising edge of clk; all outputs are registered or decoded from registered state, never combinational from inputs.
- States and transitions:
  - NORMAL: level >= WARN_LEVEL -> WARN, cnt=0. A is not counted in NORMAL.
  - WARN:
    - level < WARN_LEVEL -> NORMAL, cnt=0.
    - Otherwise, A=0 -> cnt=0.
    - Otherwise, A=1 and cnt == FULL_CYCLES-1 -> ALARM, cnt=0, shed=1.
    - Otherwise, A=1 -> cnt+1.
  - ALARM: ack=1 and level <= CLEAR_LEVEL -> HOLD, cnt=0. ack is ignored while level > CLEAR_LEVEL; it is not latched.
  - HOLD:
    - A=1 -> ALARM, cnt=0, shed=1. This takes priority over terminal count.
    - Otherwise, cnt == HOLD_CYCLES-1 -> NORMAL, cnt=0.
    - Otherwise, cnt+1.
- Single 8-bit cnt shared by WARN dwell and HOLD timing; it is reset on every state change and cannot wrap within legal parameter ranges.
- shed is a registered pulse, high exactly on the first cycle state==ALARM, otherwise 0.
- Peak register (see Configuration):
  - peak_clr=1 loads the current level; peak_clr has priority over tracking.
  - Otherwise, level > peak loads level.
  - Otherwise, peak holds.

## Timing
- NORMAL->WARN: warn rises one cycle after the first edge that samples level >= WARN_LEVEL.
- WARN->ALARM: with A=1 at FULL_CYCLES consecutive edges in WARN, alarm and shed rise after the FULL_CYCLES-th such edge. A single A=0 sample restarts the count.
- With FULL_CYCLES=1, alarm rises on the first edge in WARN sampling A=1.
- HOLD lasts exactly HOLD_CYCLES cycles if A stays 0, then warn falls.
- A reset assertion mid-operation (any state, any cnt) immediately forces all outputs to their reset values. The first edge after release evaluates from NORMAL.
- Peak updates one cycle after the sampled level.

## Configuration
- LOAD_PEAK_EN defined: peak register implemented as in Operation.
- LOAD_PEAK_EN undefined: peak held at 3'b000, peak_clr ignored, no register inferred. Ports exist in both builds; FSM behaviour is identical.

## Test plan
- Reset: hold reset=0 with level=7, A=1 and toggle clk -> warn=0, alarm=0, shed=0, peak=0 throughout; release -> warn=1 one cycle later.
- Qualified alarm (defaults): level=7, A=1 continuously from NORMAL -> warn at edge 1, alarm=1 and shed=1 for one cycle at edge 5, then alarm stays 1 and shed=0.
- Glitch filter: in WARN, drive A pattern 1,1,1,0,1,1,1 -> no alarm; a 4th consecutive 1 -> alarm.
- Hysteresis/ack: in ALARM, ack=1 with level=4 -> stays ALARM. Drop level to 3 -> HOLD (alarm=0, warn=1), then NORMAL after 8 cycles.
- Re-trigger: in HOLD, cycle 2, A=1 -> ALARM with a new shed pulse. Also assert reset for 1 cycle mid-WARN with cnt=2 -> NORMAL, cnt=0.
- Peak (LOAD_PEAK_EN): level sequence 2,6,4 -> peak=6. peak_clr with level=4 -> peak=4. Rebuilt without the macro -> peak=0 for the same sequence.
